// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: bundles the two requester handshakes, the adder operand/result
// bus and the two response channels of adder_arbiter.
// slave  : the arbiter's view.
// master : the surrounding logic (clients plus adder instance).
interface adder_arbiter_if #(
   parameter int unsigned WIDTH = 16
);
   // Requester 0
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_cin;

   // Requester 1
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_cin;

   // Shared adder
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   // Responses
   logic             rsp0_valid;
   logic [WIDTH-1:0] rsp0_sum;
   logic             rsp0_cout;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp1_sum;
   logic             rsp1_cout;

   logic             busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      input  req1_valid, req1_a, req1_b, req1_cin,
      input  add_sum, add_cout,
      output req0_ready, req1_ready,
      output add_a, add_b, add_cin,
      output rsp0_valid, rsp0_sum, rsp0_cout,
      output rsp1_valid, rsp1_sum, rsp1_cout,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      output req1_valid, req1_a, req1_b, req1_cin,
      output add_sum, add_cout,
      input  req0_ready, req1_ready,
      input  add_a, add_b, add_cin,
      input  rsp0_valid, rsp0_sum, rsp0_cout,
      input  rsp1_valid, rsp1_sum, rsp1_cout,
      input  busy
   );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one fixed-latency pipelined adder between two valid/ready
// requesters. One operation is accepted per cycle; an ID tag follows each operation
// so the result is steered back to its issuer.
//
// Build option: define ADD_ARB_FIXED_PRIO_EN to give requester 0 strict priority
// instead of round-robin. Latency, routing and reset behaviour are unchanged.
module adder_arbiter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned ADD_LAT = 2
) (
   input  logic           clk,
   input  logic           reset,
   adder_arbiter_if.slave bus
);

   // Tag pipeline: bit 0 travels with the operand registers, bits 1..ADD_LAT follow
   // the adder stages, so bit ADD_LAT lines up with add_sum/add_cout.
   localparam int unsigned TagMsb = ADD_LAT;

   logic             xfer;
   logic             win_id;

   logic [WIDTH-1:0] add_a_d,   add_a_q;
   logic [WIDTH-1:0] add_b_d,   add_b_q;
   logic             add_cin_d, add_cin_q;

   logic [TagMsb:0]  tag_vld_d, tag_vld_q;
   logic [TagMsb:0]  tag_id_d,  tag_id_q;

   logic             ret_vld;
   logic             ret_id;

   logic             rsp0_valid_d, rsp0_valid_q;
   logic [WIDTH-1:0] rsp0_sum_d,   rsp0_sum_q;
   logic             rsp0_cout_d,  rsp0_cout_q;
   logic             rsp1_valid_d, rsp1_valid_q;
   logic [WIDTH-1:0] rsp1_sum_d,   rsp1_sum_q;
   logic             rsp1_cout_d,  rsp1_cout_q;

`ifndef ADD_ARB_FIXED_PRIO_EN
   // Most recent winner; reset to 1 so requester 0 wins the first contention.
   logic             last_d, last_q;
`endif

   // Pick the winner for this cycle; a transfer happens whenever anyone is valid.
   always_comb begin
      xfer = bus.req0_valid | bus.req1_valid;
`ifdef ADD_ARB_FIXED_PRIO_EN
      win_id = ~bus.req0_valid;
`else
      win_id = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         win_id = ~last_q;
      end
`endif
   end

   assign bus.req0_ready = bus.req0_valid & ~win_id;
   assign bus.req1_ready = bus.req1_valid &  win_id;

   // Operand registers and tag shift; idle cycles feed zeros and an invalid tag.
   always_comb begin
      add_a_d   = '0;
      add_b_d   = '0;
      add_cin_d = 1'b0;
      if (xfer) begin
         if (win_id) begin
            add_a_d   = bus.req1_a;
            add_b_d   = bus.req1_b;
            add_cin_d = bus.req1_cin;
         end else begin
            add_a_d   = bus.req0_a;
            add_b_d   = bus.req0_b;
            add_cin_d = bus.req0_cin;
         end
      end
      if (TagMsb == 0) begin
         tag_vld_d = xfer;
         tag_id_d  = win_id & xfer;
      end else begin
         tag_vld_d = {tag_vld_q[TagMsb-1:0], xfer};
         tag_id_d  = {tag_id_q[TagMsb-1:0], win_id & xfer};
      end
   end

`ifndef ADD_ARB_FIXED_PRIO_EN
   // Pointer moves only when something was actually granted.
   always_comb begin
      last_d = last_q;
      if (xfer) begin
         last_d = win_id;
      end
   end
`endif

   // Retire: the aligned tag routes the adder output to one response port; the
   // other port drops its valid but keeps its last sum/carry.
   always_comb begin
      ret_vld      = tag_vld_q[TagMsb];
      ret_id       = tag_id_q[TagMsb];
      rsp0_valid_d = ret_vld & ~ret_id;
      rsp1_valid_d = ret_vld &  ret_id;
      rsp0_sum_d   = rsp0_sum_q;
      rsp0_cout_d  = rsp0_cout_q;
      rsp1_sum_d   = rsp1_sum_q;
      rsp1_cout_d  = rsp1_cout_q;
      if (rsp0_valid_d) begin
         rsp0_sum_d  = bus.add_sum;
         rsp0_cout_d = bus.add_cout;
      end
      if (rsp1_valid_d) begin
         rsp1_sum_d  = bus.add_sum;
         rsp1_cout_d = bus.add_cout;
      end
   end

   // All state; reset discards in-flight tags so no stale responses appear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         add_a_q      <= '0;
         add_b_q      <= '0;
         add_cin_q    <= 1'b0;
         tag_vld_q    <= '0;
         tag_id_q     <= '0;
         rsp0_valid_q <= 1'b0;
         rsp0_sum_q   <= '0;
         rsp0_cout_q  <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_sum_q   <= '0;
         rsp1_cout_q  <= 1'b0;
      end else begin
         add_a_q      <= add_a_d;
         add_b_q      <= add_b_d;
         add_cin_q    <= add_cin_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_sum_q   <= rsp0_sum_d;
         rsp0_cout_q  <= rsp0_cout_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_sum_q   <= rsp1_sum_d;
         rsp1_cout_q  <= rsp1_cout_d;
      end
   end

`ifndef ADD_ARB_FIXED_PRIO_EN
   // Round-robin pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign bus.add_a      = add_a_q;
   assign bus.add_b      = add_b_q;
   assign bus.add_cin    = add_cin_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp0_sum   = rsp0_sum_q;
   assign bus.rsp0_cout  = rsp0_cout_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp1_sum   = rsp1_sum_q;
   assign bus.rsp1_cout  = rsp1_cout_q;
   assign bus.busy       = (|tag_vld_q) | rsp0_valid_q | rsp1_valid_q;

   // Grants are exclusive and never raised without their valid.
   a_one_ready : assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));
   a_ready0_vld : assert property (@(posedge clk) bus.req0_ready |-> bus.req0_valid);
   a_ready1_vld : assert property (@(posedge clk) bus.req1_ready |-> bus.req1_valid);
   // Only one operation retires per cycle.
   a_one_rsp : assert property (@(posedge clk) disable iff (reset)
      !(bus.rsp0_valid && bus.rsp1_valid));

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed plus randomized stimulus for adder_arbiter, checked
// against a transaction-level model (grant rule, expected-result queue with due
// cycles, held response values).
module tb_adder_arbiter;

   localparam int unsigned Width  = 16;
   localparam int unsigned AddLat = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   adder_arbiter_if #(.WIDTH(Width)) bus ();

   adder_arbiter #(
      .WIDTH   (Width),
      .ADD_LAT (AddLat)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stand-in for the pipelined adder: AddLat edges from operands to result.
   logic [Width:0] pipe [AddLat];
   always @(posedge clk) begin
      pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{Width{1'b0}}, bus.add_cin};
      for (int i = 1; i < AddLat; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.add_sum  = pipe[AddLat-1][Width-1:0];
   assign bus.add_cout = pipe[AddLat-1][Width];

   // Count of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int             due;
      bit             id;
      logic [Width:0] res;
   } exp_t;

   exp_t           expq[$];
   bit             last_m = 1'b1;
   logic [Width:0] hold0  = '0;
   logic [Width:0] hold1  = '0;
   bit             gnt0   = 1'b0;
   bit             gnt1   = 1'b0;
   int             total  = 0;
   int             bad    = 0;

   logic           v0, v1, c0, c1;
   logic [15:0]    a0, b0, a1, b1;
   int             n0, n1, steps;
   bit             pend1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Response/busy check for the cycle that just began.
   task automatic check_rsp();
      bit e0, e1, busy_e;
      busy_e = (expq.size() != 0);
      e0 = 1'b0;
      e1 = 1'b0;
      if (expq.size() != 0 && expq[0].due == cyc) begin
         if (expq[0].id) begin
            e1    = 1'b1;
            hold1 = expq[0].res;
         end else begin
            e0    = 1'b1;
            hold0 = expq[0].res;
         end
         void'(expq.pop_front());
      end
      check_eq("rsp0_valid", bus.rsp0_valid, e0);
      check_eq("rsp1_valid", bus.rsp1_valid, e1);
      check_eq("rsp0_sum",   bus.rsp0_sum,   hold0[Width-1:0]);
      check_eq("rsp0_cout",  bus.rsp0_cout,  hold0[Width]);
      check_eq("rsp1_sum",   bus.rsp1_sum,   hold1[Width-1:0]);
      check_eq("rsp1_cout",  bus.rsp1_cout,  hold1[Width]);
      check_eq("busy",       bus.busy,       busy_e);
   endtask

   // One clock cycle: check outputs, offer the given requests, check the grant.
   task automatic step(input logic p0, input logic [15:0] pa0, input logic [15:0] pb0,
                       input logic pc0, input logic p1, input logic [15:0] pa1,
                       input logic [15:0] pb1, input logic pc1);
      bit   win;
      exp_t e;
      @(negedge clk);
      check_rsp();
      bus.req0_valid = p0;
      bus.req0_a     = pa0;
      bus.req0_b     = pb0;
      bus.req0_cin   = pc0;
      bus.req1_valid = p1;
      bus.req1_a     = pa1;
      bus.req1_b     = pb1;
      bus.req1_cin   = pc1;
      #1;
`ifdef ADD_ARB_FIXED_PRIO_EN
      win = p0 ? 1'b0 : 1'b1;
`else
      if (p0 && p1) win = (last_m == 1'b0) ? 1'b1 : 1'b0;
      else if (p0)  win = 1'b0;
      else          win = 1'b1;
`endif
      gnt0 = p0 && (win == 1'b0);
      gnt1 = p1 && (win == 1'b1);
      check_eq("req0_ready", bus.req0_ready, gnt0);
      check_eq("req1_ready", bus.req1_ready, gnt1);
      if (gnt0 || gnt1) begin
         // Handshake edge is cyc+1; response visible after edge cyc+1+AddLat+1.
         e.due = cyc + AddLat + 2;
         e.id  = win;
         e.res = win ? ({1'b0, pa1} + {1'b0, pb1} + 17'(pc1))
                     : ({1'b0, pa0} + {1'b0, pb0} + 17'(pc0));
         expq.push_back(e);
         last_m = win;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      reset          = 1'b1;
      #1;
      check_eq("rst_busy",       bus.busy,       1'b0);
      check_eq("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
      check_eq("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
      check_eq("rst_add_a",      bus.add_a,      16'd0);
      check_eq("rst_add_cin",    bus.add_cin,    1'b0);
      expq.delete();
      last_m = 1'b1;
      hold0  = '0;
      hold1  = '0;
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      repeat (n) @(negedge clk);
      // Ready tracks valid combinationally even while reset is asserted.
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check_eq("rst_req0_ready", bus.req0_ready, 1'b1);
      check_eq("rst_req1_ready", bus.req1_ready, 1'b0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [15:0] rand16();
      if ($urandom_range(3) == 0) return 16'hFFFF;
      return 16'($urandom);
   endfunction

   initial begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
      bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;

      do_reset(2);

      // Single request from requester 0.
      step(1'b1, 16'd29, 16'd85, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
      idle(AddLat + 3);
      check_eq("t1_sum",  bus.rsp0_sum,  16'd114);
      check_eq("t1_cout", bus.rsp0_cout, 1'b0);

      // Contention straight after reset.
      do_reset(1);
      step(1'b1, 16'd105, 16'd15, 1'b0, 1'b1, 16'd121, 16'd15, 1'b0);
      check_eq("t2_first_req0", gnt0, 1'b1);
      step(!gnt0, 16'd105, 16'd15, 1'b0, !gnt1, 16'd121, 16'd15, 1'b0);
      idle(AddLat + 3);
      check_eq("t2_sum0", bus.rsp0_sum, 16'd120);
      check_eq("t2_sum1", bus.rsp1_sum, 16'd136);

      // Back-to-back streams, both continuously valid.
      n0 = 0; n1 = 0; steps = 0;
      while ((n0 < 6 || n1 < 6) && steps < 40) begin
         step(n0 < 6, 16'(233 + 1824 * n0), 16'd527, 1'b0,
              n1 < 6, 16'(1145 + 1824 * n1), 16'd527, 1'b0);
         if (gnt0) n0++;
         if (gnt1) n1++;
         steps++;
      end
      check_eq("t3_cycles", steps, 12);
      idle(AddLat + 3);

      // Overflow on requester 1.
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
      idle(AddLat + 3);
      check_eq("t4_sum",  bus.rsp1_sum,  16'd0);
      check_eq("t4_cout", bus.rsp1_cout, 1'b1);

      // Reset with two operations in flight.
      step(1'b1, 16'd10, 16'd20, 1'b0, 1'b1, 16'd30, 16'd40, 1'b1);
      step(!gnt0, 16'd10, 16'd20, 1'b0, !gnt1, 16'd30, 16'd40, 1'b1);
      do_reset(1);
      step(1'b1, 16'd1, 16'd2, 1'b0, 1'b1, 16'd3, 16'd4, 1'b0);
      check_eq("t5_first_req0", gnt0, 1'b1);
      step(1'b0, 16'd0, 16'd0, 1'b0, !gnt1, 16'd3, 16'd4, 1'b0);
      idle(AddLat + 3);

      // Both valid for 4 cycles, then requester 0 drops out.
      pend1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 16'(k * 7), 16'd3, 1'b0, pend1, 16'd500, 16'd600, 1'b1);
         if (gnt1) pend1 = 1'b0;
      end
      step(1'b0, 16'd0, 16'd0, 1'b0, pend1, 16'd500, 16'd600, 1'b1);
      idle(AddLat + 3);

      // Randomized traffic with a reset in the middle.
      v0 = 1'b0; v1 = 1'b0;
      a0 = '0; b0 = '0; c0 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
      gnt0 = 1'b0; gnt1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            do_reset(1);
            v0 = 1'b0;
            v1 = 1'b0;
         end
         if (v0 && !gnt0) begin
            if ($urandom_range(9) == 0) v0 = 1'b0;
         end else begin
            v0 = ($urandom_range(9) < 6);
            a0 = rand16(); b0 = rand16(); c0 = 1'($urandom_range(1));
         end
         if (v1 && !gnt1) begin
            if ($urandom_range(9) == 0) v1 = 1'b0;
         end else begin
            v1 = ($urandom_range(9) < 6);
            a1 = rand16(); b1 = rand16(); c1 = 1'($urandom_range(1));
         end
         step(v0, a0, b0, c0, v1, a1, b1, c1);
      end
      idle(AddLat + 4);
      check_eq("drain_empty", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
